// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / restoring-divide sequencer producing a lo/hi result pair.
// Define MULDIV_EARLY_TERM_EN to let multiplies leave BUSY once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             done,
  output logic [1:0]       reg_write,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: product accumulator; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   mcand, opb;
  logic               is_div, sgn, rsgn;

  logic               valid_op, accept, last_step;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_acc, acc_nx, prod_s;

  assign valid_op = (op == 2'b01) || (op == 2'b10);
  assign accept   = start && valid_op && (state == IDLE || state == DONE);
  assign mag_a    = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b    = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // Shift-add: add multiplicand into the upper half, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? mcand : '0)};

  // Restoring divide: shift next dividend bit into the partial remainder, subtract if it fits.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opb};
  assign div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, opb}) : div_trial[WIDTH-1:0];

  assign step_acc = is_div ? {div_rem, acc[WIDTH-2:0], div_ge}
                           : {mul_sum, acc[WIDTH-1:1]};

`ifdef MULDIV_EARLY_TERM_EN
  logic [CW-1:0] rem_shift;
  assign rem_shift = CW'(WIDTH - 1) - cnt;
  assign last_step = (cnt == CW'(WIDTH - 1)) || (!is_div && ((opb >> 1) == '0));
  // Skipped iterations would only have shifted, so apply them all at once.
  assign acc_nx    = last_step ? (step_acc >> rem_shift) : step_acc;
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign acc_nx    = step_acc;
`endif

  assign prod_s = sgn ? -acc : acc;

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    done      = 1'b0;
    reg_write = 2'b00;
    case (state)
      IDLE: if (accept) state_nx = (op == 2'b10 && operand_b == '0) ? DONE : BUSY;
      BUSY: begin
        stall = 1'b1;
        if (last_step) state_nx = FIX;
      end
      FIX: begin
        stall    = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done      = 1'b1;
        reg_write = 2'b11;
        if (accept) state_nx = (op == 2'b10 && operand_b == '0) ? DONE : BUSY;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (accept) stall = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      opb         <= '0;
      is_div      <= 1'b0;
      sgn         <= 1'b0;
      rsgn        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt         <= '0;
        mcand       <= mag_a;
        opb         <= mag_b;
        is_div      <= (op == 2'b10);
        sgn         <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        rsgn        <= operand_a[WIDTH-1];
        div_by_zero <= 1'b0;
        acc         <= (op == 2'b10) ? {{WIDTH{1'b0}}, mag_a} : '0;
        if (op == 2'b10 && operand_b == '0) begin
          result_lo   <= '1;
          result_hi   <= operand_a;
          div_by_zero <= 1'b1;
        end
      end else if (state == BUSY) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (!is_div) opb <= opb >> 1;
      end else if (state == FIX) begin
        if (is_div) begin
          result_lo <= sgn  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
          result_hi <= rsgn ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
          result_lo <= prod_s[WIDTH-1:0];
          result_hi <= prod_s[2*WIDTH-1:WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a plain-arithmetic signed mul/div model.
module tb_muldiv_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         stall, done, div_by_zero;
  logic [1:0]   reg_write;
  logic [W-1:0] result_lo, result_hi;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand_a(a), .operand_b(b),
    .stall(stall), .done(done), .reg_write(reg_write),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] e_lo, e_hi;
  logic         e_dbz;
  int           e_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, p, q, r, m, h;
    sx = $signed(x);
    sy = $signed(y);
    e_dbz = 1'b0;
    e_lat = W + 2;
    if (o == 2'b01) begin
      p = sx * sy;
      e_lo = p[15:0];
      e_hi = p[31:16];
`ifdef MULDIV_EARLY_TERM_EN
      m = (sy < 0) ? -sy : sy;
      h = 0;
      for (int i = 0; i <= W; i++) if (((m >> i) & 1) == 1) h = i + 1;
      e_lat = 2 + ((h < 1) ? 1 : h);
`else
      m = 0;
      h = 0;
`endif
    end else if (y == '0) begin
      e_lo  = '1;
      e_hi  = x;
      e_dbz = 1'b1;
      e_lat = 1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e_lo = q[15:0];
      e_hi = r[15:0];
    end
  endtask

  // Called in the low phase of the intended acceptance cycle; returns just after that edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    #1 chk("stall_accept", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0; op = 2'b00;
  endtask

  // c0 is the cycle number (relative to acceptance) of the next falling edge.
  task automatic wait_done(input string tag, input int c0);
    int lat, stall_bad;
    lat = 0;
    stall_bad = 0;
    for (int c = c0; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (!stall) stall_bad++;
    end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_lo"}, {16'b0, result_lo}, {16'b0, e_lo});
    chk({tag, "_hi"}, {16'b0, result_hi}, {16'b0, e_hi});
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e_dbz});
    chk({tag, "_rw"}, {30'b0, reg_write}, 32'd3);
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_stall_busy"}, stall_bad, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int nd;
    logic [W-1:0] x, y;
    logic [1:0] o;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rw", {30'b0, reg_write}, 0);
    chk("rst_res", {result_hi, result_lo}, 0);
    chk("rst_dbz", {31'b0, div_by_zero}, 0);
    rst = 1'b0;

    @(negedge clk); issue(2'b01, 16'h0007, 16'hFFFD); wait_done("mul_7x-3", 1);
    @(negedge clk); issue(2'b10, 16'hFFF9, 16'h0002); wait_done("div_-7/2", 1);
    @(negedge clk); issue(2'b10, 16'h0064, 16'h0000); wait_done("div_by0", 1);
    @(negedge clk);
    chk("dbz_hold", {31'b0, div_by_zero}, 1);
    issue(2'b01, 16'h8000, 16'h8000); wait_done("mul_min", 1);
    @(negedge clk); issue(2'b10, 16'h8000, 16'hFFFF); wait_done("div_wrap", 1);

    // reset in cycle 5 of a multiply
    @(negedge clk); issue(2'b01, 16'h1234, 16'h0F0F);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", {31'b0, stall}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_res", {result_hi, result_lo}, 0);
    chk("midrst_dbz", {31'b0, div_by_zero}, 0);
    nd = 0;
    repeat (20) begin @(negedge clk); if (done) nd++; end
    chk("midrst_no_strobe", nd, 0);

    // start in BUSY is ignored
    @(negedge clk); issue(2'b01, 16'h0003, 16'h0004);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 2'b10; a = 16'h0064; b = 16'h0000;
    @(posedge clk);
    #1 start = 1'b0; op = 2'b00;
    wait_done("busy_ignore", 4);

    // invalid op in IDLE
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h0005; b = 16'h0003;
    #1 chk("op00_stall", {31'b0, stall}, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("op00_done", {31'b0, done}, 0);
    chk("op00_stall2", {31'b0, stall}, 0);

    // back-to-back: second accept in the DONE cycle
    @(negedge clk); issue(2'b01, 16'h0011, 16'h0022); wait_done("b2b_1", 1);
    issue(2'b01, 16'hFF00, 16'h0101); wait_done("b2b_2", 1);

`ifdef MULDIV_EARLY_TERM_EN
    @(negedge clk); issue(2'b01, 16'h0005, 16'h0003); wait_done("early_5x3", 1);
`endif

    for (int i = 0; i < 40; i++) begin
      o = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      x = pick();
      y = ($urandom_range(0, 9) == 0) ? 16'h0000 : pick();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(o, x, y);
      wait_done("rand", 1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
